// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of fetch_sequencer: the instruction-memory port, the redirect request and the
// decode hand-off. The sequencer takes the master side; memory/decode/branch logic take the slave side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_address;
  logic [15:0]       imem_instruction;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  // Decode hand-off: a word moves on every rising edge where out_valid && out_ready. While
  // out_valid is high and out_ready is low, out_instruction/out_pc are held unchanged; out_valid
  // falls without a transfer only on redirect or reset.
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instruction;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output imem_address, out_valid, out_instruction, out_pc,
    input  imem_instruction, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_address, out_valid, out_instruction, out_pc,
    output imem_instruction, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and fetch controller: issues imem reads, absorbs the 1-cycle read latency and
// buffers words in a 2-entry queue for decode. Optional halt-on-zero-word via FETCH_HALT_EN.
module fetch_sequencer #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  fetch_sequencer_if.master   bus,
  output logic                busy,
  output logic                halted,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              pending;
  logic [1:0]        count;
  logic [15:0]       q_instr [2];
  logic [ADDR_W-1:0] q_pc    [2];

  logic       pop;
  logic       push;
  logic       halt_hit;
  logic       issue;
  logic [2:0] occ;

  assign pop = (count != 2'd0) && bus.out_ready;

`ifdef FETCH_HALT_EN
  assign halt_hit = pending && (bus.imem_instruction == 16'h0000);
`else
  assign halt_hit = 1'b0;
`endif

  assign push = pending && !halt_hit;
  // Counting the word leaving this cycle lets a new read issue while the queue is streaming.
  assign occ   = 3'(count) + 3'(pending) - 3'(pop);
  assign issue = (state == RUN) && !halt_hit && (occ < 3'd2);

  assign bus.imem_address    = pc;
  assign bus.out_valid       = (count != 2'd0);
  assign bus.out_instruction = q_instr[0];
  assign bus.out_pc          = q_pc[0];
  assign busy                = (state == RUN);
  assign dbg_state           = state;

`ifdef FETCH_HALT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      count      <= 2'd0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
    end else if (bus.redirect_valid) begin
      // Flush wins over everything: queued words and the in-flight read are dropped.
      pending <= 1'b0;
      count   <= 2'd0;
      pc      <= bus.redirect_pc & PC_MASK;
      if (state == HALT) state <= RUN;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (halt_hit) state <= HALT;
        default: ;
      endcase

      if (issue) begin
        pending    <= 1'b1;
        pending_pc <= pc;
        pc         <= (pc + ADDR_W'(1)) & PC_MASK;
      end else begin
        pending    <= 1'b0;
      end

      // Head lives in slot 0; it only changes on a pop or when filling an empty queue.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            q_instr[0] <= bus.imem_instruction;
            q_pc[0]    <= pending_pc;
          end else begin
            q_instr[1] <= bus.imem_instruction;
            q_pc[1]    <= pending_pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          q_instr[0] <= q_instr[1];
          q_pc[0]    <= q_pc[1];
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q_instr[0] <= bus.imem_instruction;
            q_pc[0]    <= pending_pc;
          end else begin
            q_instr[0] <= q_instr[1];
            q_pc[0]    <= q_pc[1];
            q_instr[1] <= bus.imem_instruction;
            q_pc[1]    <= pending_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
